// File: rtl/dram_arbiter.sv
// dram_arbiter
// Round-robin arbiter that lets NUM_CORES cores share one single-port data
// memory. Each transaction takes IDLE -> ACCESS -> RESP (3 cycles). The memory
// strobe is high only in ACCESS. Read data comes back in RESP and is captured
// into the core's rdata slice on the RESP exit edge, together with the done
// pulse.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_core_addr         NUM_CORES x ADDR_W packed request addresses
//   i_core_read/write   NUM_CORES x 2 packed codes, nonzero = request
//   i_core_wdata        NUM_CORES x DATA_W packed write data
//   o_core_rdata        NUM_CORES x DATA_W packed registered read data
//   o_core_done         one-cycle completion pulse per core
//   o_mem_*             shared memory address/strobes/write data
//   i_mem_rdata         memory read data, valid the cycle after o_mem_re
//   o_grant_id          current (ACCESS/RESP) or last (IDLE) winner
//   o_busy              FSM not in IDLE
//   o_conflict          sticky: a winner presented read and write together
//   o_txn_count         completed transactions, wraps at 16 bits
module dram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_core_addr,
    input  logic [NUM_CORES*2-1:0]        i_core_read,
    input  logic [NUM_CORES*2-1:0]        i_core_write,
    input  logic [NUM_CORES*DATA_W-1:0]   i_core_wdata,
    output logic [NUM_CORES*DATA_W-1:0]   o_core_rdata,
    output logic [NUM_CORES-1:0]          o_core_done,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic                          o_mem_re,
    output logic                          o_mem_we,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    output logic [2:0]                    o_grant_id,
    output logic                          o_busy,
    output logic                          o_conflict,
    output logic [15:0]                   o_txn_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                        r_state;
    logic [2:0]                    r_last;
    logic [2:0]                    r_idx;
    logic                          r_is_wr;
    logic [ADDR_W-1:0]             r_mem_addr;
    logic [DATA_W-1:0]             r_mem_wdata;
    logic                          r_mem_re;
    logic                          r_mem_we;
    logic [NUM_CORES-1:0]          r_done;
    logic [NUM_CORES*DATA_W-1:0]   r_rdata;
    logic                          r_conflict;
    logic [15:0]                   r_txn_count;

    // Request vector padded to 8 so a 3-bit index is always in range.
    logic [7:0]                    w_req;
    logic [7:0]                    w_rd_code;
    logic [7:0]                    w_wr_code;
    logic                          w_found;
    logic [2:0]                    w_win;
    logic                          w_win_rd;
    logic                          w_win_wr;
    int                            w_pos;

    // A core whose done pulse is visible this cycle has not yet had a chance
    // to drop its request, so it is masked out of arbitration for that cycle.
    always_comb begin
        w_req     = '0;
        w_rd_code = '0;
        w_wr_code = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_rd_code[k] = |i_core_read[k*2 +: 2];
            w_wr_code[k] = |i_core_write[k*2 +: 2];
            w_req[k]     = (w_rd_code[k] | w_wr_code[k]) & ~r_done[k];
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_pos    = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            w_pos = int'(r_last) + i;
            if (w_pos >= NUM_CORES) w_pos = w_pos - NUM_CORES;
            if (!w_found && w_req[w_pos[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_pos[2:0];
            end
        end
        w_win_rd = w_rd_code[w_win];
        w_win_wr = w_wr_code[w_win];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_last      <= 3'(NUM_CORES - 1);
            r_idx       <= '0;
            r_is_wr     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_conflict  <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_idx       <= w_win;
                        r_is_wr     <= w_win_wr;
                        r_mem_addr  <= i_core_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        r_mem_wdata <= i_core_wdata[int'(w_win)*DATA_W +: DATA_W];
                        // Write takes precedence over a simultaneous read.
                        r_mem_we    <= w_win_wr;
                        r_mem_re    <= ~w_win_wr;
                        if (w_win_rd && w_win_wr) r_conflict <= 1'b1;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: r_state <= RESP;
                RESP: begin
                    for (int k = 0; k < NUM_CORES; k++) begin
                        if (3'(k) == r_idx) begin
                            r_done[k] <= 1'b1;
                            if (!r_is_wr) r_rdata[k*DATA_W +: DATA_W] <= i_mem_rdata;
                        end
                    end
                    r_last      <= r_idx;
                    r_txn_count <= r_txn_count + 16'd1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_core_rdata = r_rdata;
    assign o_core_done  = r_done;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_re     = r_mem_re;
    assign o_mem_we     = r_mem_we;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_grant_id   = r_idx;
    assign o_busy       = (r_state != IDLE);
    assign o_conflict   = r_conflict;
    assign o_txn_count  = r_txn_count;

endmodule
